// File: rtl/wb_timer_io.sv
// Wishbone responder: general-purpose outputs, synchronized inputs with change detect,
// prescaled timer with compare match, and a masked registered interrupt.
module wb_timer_io #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned GPO_W    = 4,
  parameter int unsigned GPI_W    = 2,
  parameter int unsigned PRESCALE = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  input  logic              we_i,
  input  logic              stb_i,
  output logic              ack_o,
  output logic [GPO_W-1:0]  gp_o,
  input  logic [GPI_W-1:0]  gp_i,
  output logic              irq_o
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    A_GPO   = 3'd0,
    A_GPI   = 3'd1,
    A_TIMER = 3'd2,
    A_CMP   = 3'd3,
    A_FLAGS = 3'd4,
    A_IRQEN = 3'd5,
    A_RSV6  = 3'd6,
    A_RSV7  = 3'd7
  } reg_addr_e;

  logic              ack_q, ack_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [GPO_W-1:0]  gpo_q, gpo_d;
  logic [GPI_W-1:0]  sync1_q, sync2_q, gpi_prev_q;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [DATA_W-1:0] timer_q, timer_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic [1:0]        flags_q, flags_d;
  logic [1:0]        irqen_q, irqen_d;
  logic              irq_q, irq_d;

  reg_addr_e         addr;
  logic              access, wr;
  logic              wr_gpo, wr_timer, wr_cmp, wr_flags, wr_irqen;
  logic              tick, match_set, change_set;
  logic [1:0]        flag_set, flag_clr;
  logic [DATA_W-1:0] timer_inc;
  logic [DATA_W-1:0] rd_data;
  logic              unused_adr;

  assign unused_adr = ^adr_i[14:3];

  always_comb begin
    addr      = reg_addr_e'(adr_i[2:0]);
    access    = stb_i & ~ack_q;
    wr        = access & we_i;
    wr_gpo    = wr && (addr == A_GPO);
    wr_timer  = wr && (addr == A_TIMER);
    wr_cmp    = wr && (addr == A_CMP);
    wr_flags  = wr && (addr == A_FLAGS);
    wr_irqen  = wr && (addr == A_IRQEN);

    ack_d     = access;

    tick      = (psc_q == PSC_MAX);
    psc_d     = (wr_timer || tick) ? '0 : psc_q + PSC_W'(1);

    timer_inc = timer_q + DATA_W'(1);
    if (wr_timer)  timer_d = dat_i;
    else if (tick) timer_d = timer_inc;
    else           timer_d = timer_q;

    gpo_d     = wr_gpo   ? dat_i[GPO_W-1:0] : gpo_q;
    cmp_d     = wr_cmp   ? dat_i            : cmp_q;
    irqen_d   = wr_irqen ? dat_i[1:0]       : irqen_q;

    match_set  = tick && !wr_timer && (timer_inc == cmp_q);
    change_set = (sync2_q != gpi_prev_q);
    flag_set   = {change_set, match_set};
    flag_clr   = wr_flags ? dat_i[1:0] : 2'b00;
    flags_d    = (flags_q & ~flag_clr) | flag_set;

    // New sets reach irq on the edge they occur; clears and masking show one edge later.
    irq_d = |((flags_q | flag_set) & irqen_q);

    rd_data = '0;
    case (addr)
      A_GPO:   rd_data[GPO_W-1:0] = gpo_q;
      A_GPI:   rd_data[GPI_W-1:0] = sync2_q;
      A_TIMER: rd_data            = timer_q;
      A_CMP:   rd_data            = cmp_q;
      A_FLAGS: rd_data[1:0]       = flags_q;
      A_IRQEN: rd_data[1:0]       = irqen_q;
      default: rd_data            = '0;
    endcase

    dat_d = (access && !we_i) ? rd_data : dat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gpo_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      gpi_prev_q <= '0;
      psc_q      <= '0;
      timer_q    <= '0;
      cmp_q      <= '0;
      flags_q    <= '0;
      irqen_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      gpo_q      <= gpo_d;
      sync1_q    <= gp_i;
      sync2_q    <= sync1_q;
      gpi_prev_q <= sync2_q;
      psc_q      <= psc_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      flags_q    <= flags_d;
      irqen_q    <= irqen_d;
      irq_q      <= irq_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign gp_o  = gpo_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer_io.sv
// Directed bench for wb_timer_io (PRESCALE=4); bus ops start and end on a falling clock edge.
module tb_wb_timer_io;

  logic        clk;
  logic        rst_n;
  logic [14:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic        stb;
  logic        ack;
  logic [3:0]  gp_o;
  logic [1:0]  gp_i;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wb_timer_io #(
    .DATA_W  (32),
    .GPO_W   (4),
    .GPI_W   (2),
    .PRESCALE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .adr_i(adr),
    .dat_i(dat_w),
    .dat_o(dat_r),
    .we_i (we),
    .stb_i(stb),
    .ack_o(ack),
    .gp_o (gp_o),
    .gp_i (gp_i),
    .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Op launched at falling edge N_x commits/samples at rising edge x+1, returns at N_{x+2}.
  task automatic bus_wr(input logic [14:0] a, input logic [31:0] d);
    adr = a; dat_w = d; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [14:0] a, output logic [31:0] d, output logic acked);
    adr = a; we = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    acked = ack; d = dat_r;
    @(negedge clk); stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        a;
    logic [2:0]  order [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd6, 3'd7};
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; gp_i = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (dat_r !== '0)  begin errors++; $display("FAIL reset_dat got %h exp 0", dat_r); end
    checks++; if (gp_o !== 4'h0) begin errors++; $display("FAIL reset_gpo got %h exp 0", gp_o); end
    checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int unsigned i = 0; i < 8; i++) begin
      bus_rd({12'd0, order[i]}, d, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL reset_rd_ack addr %0d got %b exp 1", order[i], a); end
      checks++; if (d !== '0)   begin errors++; $display("FAIL reset_rd addr %0d got %h exp 0", order[i], d); end
    end
  endtask

  task automatic test_back_to_back;
    adr = 15'd0; we = 1'b0; stb = 1'b1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_pre got %b exp 0", ack); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", ack); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", ack); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b exp 1", ack); end
    @(negedge clk); stb = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b exp 0", ack); end
    @(negedge clk);
  endtask

  task automatic test_gpo;
    logic [31:0] d;
    logic        a;
    bus_wr(15'd0, 32'hFFFF_FFFF);
    checks++; if (gp_o !== 4'hF) begin errors++; $display("FAIL gpo_pin got %h exp f", gp_o); end
    bus_rd(15'd0, d, a);
    checks++; if (d !== 32'h0000_000F) begin errors++; $display("FAIL gpo_rd got %h exp 0000000f", d); end
    bus_wr(15'h0008, 32'h0000_0005);
    checks++; if (gp_o !== 4'h5) begin errors++; $display("FAIL gpo_alias_pin got %h exp 5", gp_o); end
    bus_rd(15'd0, d, a);
    checks++; if (d !== 32'h0000_0005) begin errors++; $display("FAIL gpo_alias_rd got %h exp 00000005", d); end
    bus_wr(15'd1, 32'hFFFF_FFFF);
    bus_rd(15'd1, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL gpi_wr_ignored got %h exp 0", d); end
    bus_wr(15'd6, 32'h1234_5678);
    bus_rd(15'd6, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsv6 got %h exp 0", d); end
  endtask

  task automatic test_timer_wrap;
    logic [31:0] d;
    logic        a;
    bus_wr(15'd3, 32'd5);
    bus_wr(15'd2, 32'hFFFF_FFFE);          // write edge W, now at N_{W+1}
    idle(1);
    bus_rd(15'd2, d, a);                   // value after W+2
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL timer_hold got %h exp fffffffe", d); end
    bus_rd(15'd2, d, a);                   // value after W+4
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_tick got %h exp ffffffff", d); end
    idle(2);
    bus_rd(15'd2, d, a);                   // value after W+8
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h exp 0", d); end
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_no_flag got %h exp 0", d); end
  endtask

  task automatic test_match_irq;
    logic [31:0] d;
    logic        a;
    bus_wr(15'd2, 32'h0000_0100);
    bus_wr(15'd3, 32'd3);
    bus_wr(15'd4, 32'd3);
    bus_wr(15'd5, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    bus_wr(15'd2, 32'd0);                  // write edge W, ticks at W+4, W+8, W+12
    idle(10);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_match got %b exp 1", irq); end
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL match_flag got %h exp 1", d); end
    bus_wr(15'd4, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL match_w1c got %h exp 0", d); end
    bus_wr(15'd2, 32'd7);
    bus_wr(15'd3, 32'd7);                  // equals current TIMER
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL cmp_eq_no_match got %h exp 0", d); end
    bus_wr(15'd2, 32'd6);                  // TIMER+1 == CMP but a write never matches
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL timer_wr_no_match got %h exp 0", d); end
  endtask

  task automatic test_change;
    logic [31:0] d;
    logic        a;
    bus_wr(15'd3, 32'hFFFF_0000);
    bus_wr(15'd4, 32'd3);
    bus_wr(15'd5, 32'd2);
    gp_i = 2'b01;                          // at N_k
    idle(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chg_early got %b exp 0", irq); end
    bus_rd(15'd1, d, a);                   // value after k+2
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL gpi_sync got %h exp 1", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL chg_irq got %b exp 1", irq); end
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL chg_flag got %h exp 2", d); end
    gp_i = 2'b00;                          // at N_m, CHANGE sets on m+3
    idle(2);
    bus_wr(15'd4, 32'd2);                  // W1C on edge m+3
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL set_wins got %h exp 2", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b exp 1", irq); end
    bus_wr(15'd4, 32'd2);
    bus_rd(15'd4, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL chg_w1c got %h exp 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chg_irq_clr got %b exp 0", irq); end
  endtask

  task automatic test_reset_mid;
    adr = 15'd2; we = 1'b0; stb = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL rst_mid_ack got %b exp 0", ack); end
    checks++; if (gp_o !== 4'h0) begin errors++; $display("FAIL rst_mid_gpo got %h exp 0", gp_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_resume_ack got %b exp 1", ack); end
    checks++; if (dat_r !== '0) begin errors++; $display("FAIL rst_resume_dat got %h exp 0", dat_r); end
    @(negedge clk); stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gpo();
    test_timer_wrap();
    test_match_irq();
    test_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
